// File: rtl/wb_group_arbiter_pkg.sv
// Shared types for the group-1 writeback arbiter: ID/packet bundle and policy select.
package wb_group_arbiter_pkg;

    localparam int unsigned LOG2_MAX_IDS = 3;
    localparam int unsigned XLEN         = 32;

    typedef logic [LOG2_MAX_IDS-1:0] id_t;

    typedef enum logic [0:0] {
        WB_ARB_OLDEST,
        WB_ARB_ROUND_ROBIN
    } wb_arb_policy_t;

    typedef struct packed {
        logic            valid;
        id_t             id;
        logic [XLEN-1:0] data;
    } wb_packet_t;

endpackage

// File: rtl/wb_group_arbiter_if.sv
// Unit-result handshake plus registered group-1 writeback bundle.
interface wb_group_arbiter_if
    import wb_group_arbiter_pkg::*;
#(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned ID_W      = LOG2_MAX_IDS,
    parameter int unsigned DATA_W    = XLEN
);
    logic [NUM_UNITS-1:0]             unit_done;
    logic [NUM_UNITS-1:0][ID_W-1:0]   unit_id;
    logic [NUM_UNITS-1:0][DATA_W-1:0] unit_data;
    logic [NUM_UNITS-1:0]             unit_ack;
    logic [ID_W-1:0]                  oldest_id;
    logic                             wb_hold;
    logic                             wb_valid;
    logic [ID_W-1:0]                  wb_id;
    logic [DATA_W-1:0]                wb_data;
    logic [15:0]                      grant_count;

    // Arbiter side
    modport slave (
        input  unit_done, unit_id, unit_data, oldest_id, wb_hold,
        output unit_ack, wb_valid, wb_id, wb_data, grant_count
    );

    // Execution units / ID management side
    modport master (
        output unit_done, unit_id, unit_data, oldest_id, wb_hold,
        input  unit_ack, wb_valid, wb_id, wb_data, grant_count
    );
endinterface

// File: rtl/wb_arb_select.sv
// Combinational grant selection: oldest-age min-reduction or rotated priority encoder.
module wb_arb_select
    import wb_group_arbiter_pkg::*;
#(
    parameter int unsigned    NUM_UNITS = 4,
    parameter int unsigned    ID_W      = 3,
    parameter int unsigned    IDX_W     = 2,
    parameter wb_arb_policy_t POLICY    = WB_ARB_OLDEST
) (
    input  logic [NUM_UNITS-1:0]           req,
    input  logic [NUM_UNITS-1:0][ID_W-1:0] unit_id,
    input  logic [ID_W-1:0]                oldest_id,
    input  logic [IDX_W-1:0]               rr_ptr,
    output logic [NUM_UNITS-1:0]           grant,
    output logic                           grant_valid,
    output logic [IDX_W-1:0]               grant_idx
);
    logic [ID_W-1:0] age;
    logic [ID_W-1:0] best_age;
    int unsigned     j;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        age         = '0;
        best_age    = '0;
        j           = 0;
        if (POLICY == WB_ARB_OLDEST) begin
            // Wrapping distance from the oldest ID; strict < keeps the lowest index on ties
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                age = unit_id[i] - oldest_id;
                if (req[i] && (!grant_valid || age < best_age)) begin
                    grant_valid = 1'b1;
                    best_age    = age;
                    grant_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < NUM_UNITS; k++) begin
                j = 32'(rr_ptr) + k;
                if (j >= NUM_UNITS) j = j - NUM_UNITS;
                if (req[IDX_W'(j)] && !grant_valid) begin
                    grant_valid = 1'b1;
                    grant_idx   = IDX_W'(j);
                end
            end
        end
        if (grant_valid) grant[grant_idx] = 1'b1;
    end
endmodule

// File: rtl/wb_group_arbiter.sv
// Writeback group-1 arbiter: picks one finished unit per cycle and registers its packet.
module wb_group_arbiter
    import wb_group_arbiter_pkg::*;
#(
    parameter int unsigned    NUM_UNITS = 4,
    parameter int unsigned    ID_W      = LOG2_MAX_IDS,
    parameter int unsigned    DATA_W    = XLEN,
    parameter wb_arb_policy_t POLICY    = WB_ARB_OLDEST
) (
    input logic               clk,
    input logic               rst,
    wb_group_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } out_pkt_t;

    logic [NUM_UNITS-1:0] req;
    logic [NUM_UNITS-1:0] grant;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    out_pkt_t             wb_q, wb_d;
    logic [15:0]          grant_count_q, grant_count_d;

    assign req = bus.unit_done & {NUM_UNITS{~(bus.wb_hold | rst)}};

    wb_arb_select #(
        .NUM_UNITS (NUM_UNITS),
        .ID_W      (ID_W),
        .IDX_W     (IDX_W),
        .POLICY    (POLICY)
    ) u_select (
        .req         (req),
        .unit_id     (bus.unit_id),
        .oldest_id   (bus.oldest_id),
        .rr_ptr      (rr_ptr_q),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        wb_d          = wb_q;
        wb_d.valid    = grant_valid;
        grant_count_d = grant_count_q;
        if (grant_valid) begin
            wb_d.id   = bus.unit_id[grant_idx];
            wb_d.data = bus.unit_data[grant_idx];
            rr_ptr_d  = (grant_idx == IDX_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
            if (grant_count_q != 16'hFFFF) grant_count_d = grant_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            wb_q          <= '0;
            grant_count_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            wb_q          <= wb_d;
            grant_count_q <= grant_count_d;
        end
    end

    assign bus.unit_ack    = grant;
    assign bus.wb_valid    = wb_q.valid;
    assign bus.wb_id       = wb_q.id;
    assign bus.wb_data     = wb_q.data;
    assign bus.grant_count = grant_count_q;
endmodule

// File: tb/tb_wb_group_arbiter.sv
// Bench for wb_group_arbiter: one OLDEST and one ROUND_ROBIN instance against a behavioural model.
module tb_wb_group_arbiter;
    import wb_group_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 3;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;
    logic [IW-1:0] oldest = '0;

    logic [N-1:0]         done  [2];
    logic [N-1:0][IW-1:0] uid   [2];
    logic [N-1:0][DW-1:0] udata [2];
    logic [N-1:0]         ack   [2];
    logic [N-1:0]         ack_s [2];
    logic                 vld   [2];
    logic [IW-1:0]        wid   [2];
    logic [DW-1:0]        wdat  [2];
    logic [15:0]          gcnt  [2];

    // Model state: what each instance's registers must hold right now
    logic          m_valid [2] = '{1'b0, 1'b0};
    logic [IW-1:0] m_id    [2] = '{'0, '0};
    logic [DW-1:0] m_data  [2] = '{'0, '0};
    int            m_cnt   [2] = '{0, 0};
    int            m_ptr   [2] = '{0, 0};
    int            g_exp   [2];

    int n_checks = 0;
    int n_errors = 0;
    int react    = 0;

    always #5 clk = ~clk;

    wb_group_arbiter_if #(.NUM_UNITS(N), .ID_W(IW), .DATA_W(DW)) bus_o ();
    wb_group_arbiter_if #(.NUM_UNITS(N), .ID_W(IW), .DATA_W(DW)) bus_r ();

    assign bus_o.unit_done = done[0];
    assign bus_o.unit_id   = uid[0];
    assign bus_o.unit_data = udata[0];
    assign bus_o.oldest_id = oldest;
    assign bus_o.wb_hold   = hold;
    assign ack[0]  = bus_o.unit_ack;
    assign vld[0]  = bus_o.wb_valid;
    assign wid[0]  = bus_o.wb_id;
    assign wdat[0] = bus_o.wb_data;
    assign gcnt[0] = bus_o.grant_count;

    assign bus_r.unit_done = done[1];
    assign bus_r.unit_id   = uid[1];
    assign bus_r.unit_data = udata[1];
    assign bus_r.oldest_id = oldest;
    assign bus_r.wb_hold   = hold;
    assign ack[1]  = bus_r.unit_ack;
    assign vld[1]  = bus_r.wb_valid;
    assign wid[1]  = bus_r.wb_id;
    assign wdat[1] = bus_r.wb_data;
    assign gcnt[1] = bus_r.grant_count;

    wb_group_arbiter #(
        .NUM_UNITS (N), .ID_W (IW), .DATA_W (DW), .POLICY (WB_ARB_OLDEST)
    ) dut_old (
        .clk (clk), .rst (rst), .bus (bus_o)
    );

    wb_group_arbiter #(
        .NUM_UNITS (N), .ID_W (IW), .DATA_W (DW), .POLICY (WB_ARB_ROUND_ROBIN)
    ) dut_rr (
        .clk (clk), .rst (rst), .bus (bus_r)
    );

    task automatic check(input string name, input int d, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    // Oldest: scan ages 0,1,2.. and take the first unit holding that ID.
    // Round robin: first requester at or after the pointer.
    function automatic int model_pick(input int d);
        if (rst || hold) return -1;
        if (d == 0) begin
            for (int a = 0; a < (1 << IW); a++)
                for (int i = 0; i < N; i++)
                    if (done[0][i] && uid[0][i] == IW'(int'(oldest) + a)) return i;
            return -1;
        end
        for (int k = 0; k < N; k++)
            if (done[1][(m_ptr[1] + k) % N]) return (m_ptr[1] + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) ack_s[d] = ack[d];
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            g_exp[d] = model_pick(d);
            check("unit_ack", d, 64'(ack[d]), (g_exp[d] >= 0) ? (64'd1 << g_exp[d]) : 64'd0);
            check("wb_valid", d, 64'(vld[d]), 64'(m_valid[d]));
            check("wb_id", d, 64'(wid[d]), 64'(m_id[d]));
            check("wb_data", d, 64'(wdat[d]), 64'(m_data[d]));
            check("grant_count", d, 64'(gcnt[d]), 64'(m_cnt[d]));
            if (rst) begin
                m_valid[d] = 1'b0;
                m_id[d]    = '0;
                m_data[d]  = '0;
                m_cnt[d]   = 0;
                m_ptr[d]   = 0;
            end else begin
                m_valid[d] = (g_exp[d] >= 0);
                if (g_exp[d] >= 0) begin
                    m_id[d]   = uid[d][g_exp[d]];
                    m_data[d] = udata[d][g_exp[d]];
                    if (m_cnt[d] < 65535) m_cnt[d]++;
                    m_ptr[d] = (g_exp[d] + 1) % N;
                end
            end
        end
    end

    function automatic logic [IW-1:0] fresh_id(input int d, input int skip);
        logic [IW-1:0] c;
        bit ok;
        do begin
            c  = IW'($urandom);
            ok = 1'b1;
            for (int i = 0; i < N; i++)
                if (i != skip && done[d][i] && uid[d][i] == c) ok = 1'b0;
        end while (!ok);
        return c;
    endfunction

    // One clock; afterwards units react to the ack they saw before the edge
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                if (ack_s[d][i]) begin
                    if (react == 0 || (react == 2 && $urandom_range(1) == 0)) begin
                        done[d][i] = 1'b0;
                    end else begin
                        if (react == 2) uid[d][i] = fresh_id(d, i);
                        udata[d][i] = $urandom;
                    end
                end else if (react == 2 && !done[d][i] && $urandom_range(2) == 0) begin
                    uid[d][i]   = fresh_id(d, i);
                    udata[d][i] = $urandom;
                    done[d][i]  = 1'b1;
                end
            end
        end
        if (react == 2) begin
            hold   = ($urandom_range(7) == 0);
            oldest = IW'($urandom);
            rst    = ($urandom_range(199) == 0);
            if (rst) begin
                done[0] = '0;
                done[1] = '0;
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            done[d]  = '0;
            uid[d]   = '0;
            udata[d] = '0;
            ack_s[d] = '0;
        end
        repeat (2) cycle();
        rst = 1'b0;

        // Single request, no contention
        for (int d = 0; d < 2; d++) begin
            done[d]     = 4'b0001;
            uid[d][0]   = 3'd5;
            udata[d][0] = 32'hDEADBEEF;
        end
        #1;
        for (int d = 0; d < 2; d++) check("single_ack", d, 64'(ack[d]), 64'h1);
        cycle();
        for (int d = 0; d < 2; d++) begin
            check("single_valid", d, 64'(vld[d]), 64'h1);
            check("single_id", d, 64'(wid[d]), 64'h5);
            check("single_data", d, 64'(wdat[d]), 64'hDEADBEEF);
        end
        cycle();
        for (int d = 0; d < 2; d++) begin
            check("single_valid_drop", d, 64'(vld[d]), 64'h0);
            check("single_count", d, 64'(gcnt[d]), 64'h1);
        end

        // Oldest-first with ID wrap-around
        oldest    = 3'd6;
        uid[0][0] = 3'd1;
        uid[0][1] = 3'd7;
        uid[0][2] = 3'd3;
        done[0]   = 4'b0111;
        #1;
        check("wrap_ack0", 0, 64'(ack[0]), 64'b0010);
        cycle();
        #1;
        check("wrap_id0", 0, 64'(wid[0]), 64'h7);
        check("wrap_ack1", 0, 64'(ack[0]), 64'b0001);
        cycle();
        #1;
        check("wrap_id1", 0, 64'(wid[0]), 64'h1);
        check("wrap_ack2", 0, 64'(ack[0]), 64'b0100);
        cycle();
        check("wrap_id2", 0, 64'(wid[0]), 64'h3);
        cycle();
        check("wrap_idle", 0, 64'(vld[0]), 64'h0);
        check("wrap_count", 0, 64'(gcnt[0]), 64'h4);

        // Round-robin fairness from a fresh pointer
        rst = 1'b1;
        cycle();
        rst   = 1'b0;
        react = 1;
        for (int i = 0; i < N; i++) begin
            uid[1][i]   = IW'(i);
            udata[1][i] = $urandom;
        end
        done[1] = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_order", 1, 64'(ack[1]), 64'd1 << (k % 4));
            cycle();
        end
        #1;
        check("rr_count", 1, 64'(gcnt[1]), 64'd8);
        react   = 0;
        done[1] = '0;

        // Hold suppresses grants and freezes the pointer (back at 0)
        uid[1][1] = 3'd2;
        uid[1][3] = 3'd4;
        done[1]   = 4'b1010;
        hold      = 1'b1;
        repeat (3) begin
            #1;
            check("hold_ack", 1, 64'(ack[1]), 64'h0);
            cycle();
            check("hold_valid", 1, 64'(vld[1]), 64'h0);
        end
        hold = 1'b0;
        #1;
        check("hold_release_ack", 1, 64'(ack[1]), 64'b0010);
        cycle();
        #1;
        check("hold_release_id", 1, 64'(wid[1]), 64'h2);
        check("hold_next_ack", 1, 64'(ack[1]), 64'b1000);
        cycle();
        check("hold_next_id", 1, 64'(wid[1]), 64'h4);

        // Reset right after a grant
        uid[1][0] = 3'd3;
        done[1]   = 4'b0001;
        #1;
        cycle();
        check("rst_pending_valid", 1, 64'(vld[1]), 64'h1);
        rst     = 1'b1;
        done[1] = 4'b0100;
        #1;
        check("rst_no_ack", 1, 64'(ack[1]), 64'h0);
        cycle();
        check("rst_valid", 1, 64'(vld[1]), 64'h0);
        check("rst_count", 1, 64'(gcnt[1]), 64'h0);
        rst     = 1'b0;
        done[1] = 4'b1111;
        #1;
        check("rst_ptr_ack", 1, 64'(ack[1]), 64'b0001);
        done[1] = '0;
        cycle();

        // Randomized traffic with hold, moving oldest_id and occasional reset
        react = 2;
        repeat (3000) cycle();
        react   = 0;
        rst     = 1'b0;
        hold    = 1'b0;
        done[0] = '0;
        done[1] = '0;
        repeat (2) cycle();

        // Grant counter saturation
        react = 1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) uid[d][i] = IW'(i);
            done[d] = 4'b1111;
        end
        repeat (65540) cycle();
        for (int d = 0; d < 2; d++) check("saturate", d, 64'(gcnt[d]), 64'hFFFF);
        react   = 0;
        done[0] = '0;
        done[1] = '0;
        repeat (2) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
